// File: rtl/ppu_vram_bus_master.sv
// PPU VRAM bus master: multiplexed AD bus with ALE, PA[13:8] and /RD,/WR.
// One request in flight; every bus pin comes straight from a flop.
module ppu_vram_bus_master #(
  parameter int ALE_CYCLES = 1,
  parameter int ACC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [13:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        ale,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  input  logic [7:0]  ad_in,
  output logic [5:0]  pa_hi,
  output logic        n_rd,
  output logic        n_wr
);

  localparam int MAXC = (ALE_CYCLES > ACC_CYCLES) ?
                        ALE_CYCLES : ACC_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] ALE_LD = CW'(ALE_CYCLES - 1);
  localparam logic [CW-1:0] ACC_LD = CW'(ACC_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_HOLD,
    S_ACCESS,
    S_END
  } state_e;

  state_e      state_q;
  logic [CW-1:0] cnt_q;
  logic        we_q;
  logic [7:0]  wdata_q;
  logic        ale_q;
  logic        ad_oe_q;
  logic [7:0]  ad_out_q;
  logic [5:0]  pa_hi_q;
  logic        n_rd_q;
  logic        n_wr_q;
  logic        rsp_valid_q;
  logic [7:0]  rsp_rdata_q;

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ale       = ale_q;
  assign ad_out    = ad_out_q;
  assign ad_oe     = ad_oe_q;
  assign pa_hi     = pa_hi_q;
  assign n_rd      = n_rd_q;
  assign n_wr      = n_wr_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      wdata_q     <= 8'h00;
      ale_q       <= 1'b0;
      ad_oe_q     <= 1'b0;
      ad_out_q    <= 8'h00;
      pa_hi_q     <= 6'h00;
      n_rd_q      <= 1'b1;
      n_wr_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            state_q  <= S_ADDR;
            cnt_q    <= ALE_LD;
            we_q     <= req_we;
            wdata_q  <= req_wdata;
            ale_q    <= 1'b1;
            ad_oe_q  <= 1'b1;
            ad_out_q <= req_addr[7:0];
            pa_hi_q  <= req_addr[13:8];
          end
        end
        S_ADDR: begin
          if (cnt_q == '0) begin
            // address stays on AD so the latch closes on ALE fall
            state_q <= S_HOLD;
            cnt_q   <= '0;
            ale_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_HOLD: begin
          state_q <= S_ACCESS;
          cnt_q   <= ACC_LD;
          if (we_q) begin
            n_wr_q   <= 1'b0;
            ad_out_q <= wdata_q;
          end else begin
            n_rd_q  <= 1'b0;
            ad_oe_q <= 1'b0;
          end
        end
        S_ACCESS: begin
          if (cnt_q == '0) begin
            state_q     <= S_END;
            cnt_q       <= '0;
            n_rd_q      <= 1'b1;
            n_wr_q      <= 1'b1;
            ad_oe_q     <= 1'b0;
            rsp_valid_q <= 1'b1;
            if (!we_q) rsp_rdata_q <= ad_in;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_END: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_vram_bus_master.sv
// Bench for ppu_vram_bus_master: default and (2,3) timing instances
// against a per-transaction phase model, plus directed literal checks.
module tb_ppu_vram_bus_master;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        req_valid;
  logic        req_we;
  logic [13:0] req_addr;
  logic [7:0]  req_wdata;
  logic [7:0]  ad_in;

  logic       rdy0, rsp_v0, ale0, oe0, nrd0, nwr0;
  logic [7:0] rdata0, ad_out0;
  logic [5:0] pa0;
  logic       rdy1, rsp_v1, ale1, oe1, nrd1, nwr1;
  logic [7:0] rdata1, ad_out1;
  logic [5:0] pa1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ppu_vram_bus_master #(.ALE_CYCLES(1), .ACC_CYCLES(2)) u0 (
    .clk(clk), .n_reset(n_reset),
    .req_valid(req_valid), .req_ready(rdy0),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_v0), .rsp_rdata(rdata0),
    .ale(ale0), .ad_out(ad_out0), .ad_oe(oe0), .ad_in(ad_in),
    .pa_hi(pa0), .n_rd(nrd0), .n_wr(nwr0)
  );

  ppu_vram_bus_master #(.ALE_CYCLES(2), .ACC_CYCLES(3)) u1 (
    .clk(clk), .n_reset(n_reset),
    .req_valid(req_valid), .req_ready(rdy1),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_v1), .rsp_rdata(rdata1),
    .ale(ale1), .ad_out(ad_out1), .ad_oe(oe1), .ad_in(ad_in),
    .pa_hi(pa1), .n_rd(nrd1), .n_wr(nwr1)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a transaction is just "cycle k since accept"; phase from k.
  int          A[2] = '{1, 2};
  int          C[2] = '{2, 3};
  bit          busy[2];
  int          k[2];
  bit          mwe[2];
  logic [13:0] maddr[2];
  logic [7:0]  mwd[2];
  logic [7:0]  mrd[2];
  logic [5:0]  mpa[2];

  task automatic model_step(int i);
    if (!n_reset) begin
      busy[i] = 0; k[i] = 0; mrd[i] = 8'h00; mpa[i] = 6'h00;
    end else if (!busy[i]) begin
      if (req_valid) begin
        busy[i] = 1; k[i] = 1;
        mwe[i] = req_we; maddr[i] = req_addr; mwd[i] = req_wdata;
        mpa[i] = req_addr[13:8];
      end
    end else begin
      if (k[i] == A[i] + C[i] + 1 && !mwe[i]) mrd[i] = ad_in;
      k[i]++;
      if (k[i] == A[i] + C[i] + 3) busy[i] = 0;
    end
  endtask

  task automatic check_inst(int i, logic a_ale, logic a_oe,
                            logic a_nrd, logic a_nwr, logic a_rsp,
                            logic a_rdy, logic [7:0] a_ad,
                            logic [5:0] a_pa, logic [7:0] a_rd);
    logic e_ale, e_oe, e_nrd, e_nwr, e_rsp, e_rdy;
    logic [7:0] e_ad;
    logic [7:0] lo;
    bit ad_chk;
    int kk;
    kk = k[i];
    lo = maddr[i][7:0];
    e_ale = 0; e_oe = 0; e_nrd = 1; e_nwr = 1; e_rsp = 0;
    e_rdy = !busy[i]; e_ad = 8'h00; ad_chk = 0;
    if (busy[i]) begin
      if (kk <= A[i]) begin
        e_ale = 1; e_oe = 1; e_ad = lo; ad_chk = 1;
      end else if (kk == A[i] + 1) begin
        e_oe = 1; e_ad = lo; ad_chk = 1;
      end else if (kk <= A[i] + C[i] + 1) begin
        if (mwe[i]) begin
          e_nwr = 0; e_oe = 1; e_ad = mwd[i]; ad_chk = 1;
        end else begin
          e_nrd = 0;
        end
      end else begin
        e_rsp = 1;
      end
    end
    chk($sformatf("u%0d.ale", i), 32'(a_ale), 32'(e_ale));
    chk($sformatf("u%0d.ad_oe", i), 32'(a_oe), 32'(e_oe));
    chk($sformatf("u%0d.n_rd", i), 32'(a_nrd), 32'(e_nrd));
    chk($sformatf("u%0d.n_wr", i), 32'(a_nwr), 32'(e_nwr));
    chk($sformatf("u%0d.rsp_valid", i), 32'(a_rsp), 32'(e_rsp));
    chk($sformatf("u%0d.req_ready", i), 32'(a_rdy), 32'(e_rdy));
    chk($sformatf("u%0d.pa_hi", i), 32'(a_pa), 32'(mpa[i]));
    chk($sformatf("u%0d.rsp_rdata", i), 32'(a_rd), 32'(mrd[i]));
    if (ad_chk)
      chk($sformatf("u%0d.ad_out", i), 32'(a_ad), 32'(e_ad));
  endtask

  always begin
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_inst(0, ale0, oe0, nrd0, nwr0, rsp_v0, rdy0, ad_out0, pa0, rdata0);
    check_inst(1, ale1, oe1, nrd1, nwr1, rsp_v1, rdy1, ad_out1, pa1, rdata1);
  end

  task automatic wait_idle();
    int n = 0;
    while (!(rdy0 && rdy1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", 32'(rdy0 && rdy1), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ale1_n, nrd1_n, rsp_n;
    n_reset = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; ad_in = '0;
    repeat (3) @(negedge clk);
    chk("rst.ale", 32'(ale0), 32'd0);
    chk("rst.ad_oe", 32'(oe0), 32'd0);
    chk("rst.n_rd", 32'(nrd0), 32'd1);
    chk("rst.n_wr", 32'(nwr0), 32'd1);
    chk("rst.rsp_valid", 32'(rsp_v0), 32'd0);
    chk("rst.ad_out", 32'(ad_out0), 32'h00);
    n_reset = 1'b1;
    @(negedge clk);
    chk("rst.req_ready0", 32'(rdy0), 32'd1);
    chk("rst.req_ready1", 32'(rdy1), 32'd1);

    // read 0x2ABC
    req_valid = 1; req_we = 0; req_addr = 14'h2ABC; ad_in = 8'h5A;
    ale1_n = 0; nrd1_n = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (ale1) ale1_n++;
      if (!nrd1) nrd1_n++;
      case (c)
        1: begin
          req_valid = 0;
          chk("rd.c1.ale", 32'(ale0), 32'd1);
          chk("rd.c1.ad_out", 32'(ad_out0), 32'hBC);
          chk("rd.c1.pa_hi", 32'(pa0), 32'h2A);
        end
        2: begin
          chk("rd.c2.ale", 32'(ale0), 32'd0);
          chk("rd.c2.ad_out", 32'(ad_out0), 32'hBC);
        end
        3, 4: begin
          chk("rd.acc.n_rd", 32'(nrd0), 32'd0);
          chk("rd.acc.ad_oe", 32'(oe0), 32'd0);
        end
        5: begin
          chk("rd.c5.rsp_valid", 32'(rsp_v0), 32'd1);
          chk("rd.c5.rsp_rdata", 32'(rdata0), 32'h5A);
        end
        6: chk("rd.c6.req_ready", 32'(rdy0), 32'd1);
        7: begin
          chk("rd23.c7.rsp_valid", 32'(rsp_v1), 32'd1);
          chk("rd23.c7.req_ready", 32'(rdy1), 32'd0);
          chk("rd23.c7.rsp_rdata", 32'(rdata1), 32'h5A);
        end
        8: chk("rd23.c8.req_ready", 32'(rdy1), 32'd1);
        default: ;
      endcase
    end
    chk("rd23.ale_cycles", ale1_n, 32'd2);
    chk("rd23.n_rd_cycles", nrd1_n, 32'd3);

    // write 0x3F00 <= 0x0F
    req_valid = 1; req_we = 1; req_addr = 14'h3F00; req_wdata = 8'h0F;
    ad_in = 8'h99;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid = 0;
        chk("wr.c1.ad_out", 32'(ad_out0), 32'h00);
        chk("wr.c1.pa_hi", 32'(pa0), 32'h3F);
      end else if (c == 3 || c == 4) begin
        chk("wr.acc.n_wr", 32'(nwr0), 32'd0);
        chk("wr.acc.ad_oe", 32'(oe0), 32'd1);
        chk("wr.acc.ad_out", 32'(ad_out0), 32'h0F);
      end else if (c == 5) begin
        chk("wr.c5.rsp_valid", 32'(rsp_v0), 32'd1);
        chk("wr.c5.rsp_rdata", 32'(rdata0), 32'h5A);
      end
    end
    wait_idle();

    // back-to-back reads with req_valid held
    req_valid = 1; req_we = 0; req_addr = 14'h1234; ad_in = 8'h11;
    rsp_n = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (rsp_v0) rsp_n++;
      if (c == 1) begin
        chk("b2b.c1.ad_out", 32'(ad_out0), 32'h34);
        chk("b2b.c1.pa_hi", 32'(pa0), 32'h12);
      end
      if (c == 2) begin
        req_addr = 14'h0567; req_wdata = 8'hEE; ad_in = 8'h22;
      end
      if (c == 3) chk("b2b.c3.pa_hi", 32'(pa0), 32'h12);
      if (c <= 5) chk("b2b.busy.req_ready", 32'(rdy0), 32'd0);
      if (c == 5) chk("b2b.c5.rsp_rdata", 32'(rdata0), 32'h22);
      if (c == 6) chk("b2b.c6.req_ready", 32'(rdy0), 32'd1);
      if (c == 7) begin
        chk("b2b.c7.ale", 32'(ale0), 32'd1);
        chk("b2b.c7.ad_out", 32'(ad_out0), 32'h67);
        chk("b2b.c7.pa_hi", 32'(pa0), 32'h05);
        req_valid = 0;
      end
    end
    chk("b2b.rsp_pulses", rsp_n, 32'd2);
    wait_idle();

    // reset during ACCESS of a write
    req_valid = 1; req_we = 1; req_addr = 14'h0100; req_wdata = 8'hAA;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 0;
    end
    chk("rstw.pre.n_wr", 32'(nwr0), 32'd0);
    n_reset = 0;
    #1;
    chk("rstw.n_wr", 32'(nwr0), 32'd1);
    chk("rstw.ad_oe", 32'(oe0), 32'd0);
    chk("rstw.n_wr1", 32'(nwr1), 32'd1);
    chk("rstw.ad_oe1", 32'(oe1), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rstw.rsp_valid", 32'(rsp_v0), 32'd0);
    end
    n_reset = 1;
    @(negedge clk);
    req_valid = 1; req_we = 0; req_addr = 14'h0ABC; ad_in = 8'hC3;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 0;
      if (c < 5) chk("rstw.rd.early_rsp", 32'(rsp_v0), 32'd0);
      if (c == 5) begin
        chk("rstw.rd.rsp_valid", 32'(rsp_v0), 32'd1);
        chk("rstw.rd.rsp_rdata", 32'(rdata0), 32'hC3);
      end
    end
    wait_idle();

    // randomized traffic, occasional resets
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      n_reset   = ($urandom_range(0, 99) != 0);
      req_valid = ($urandom_range(0, 2) != 0);
      req_we    = $urandom_range(0, 1) == 1;
      req_addr  = 14'($urandom);
      req_wdata = 8'($urandom);
      ad_in     = 8'($urandom);
    end
    @(negedge clk);
    n_reset = 1; req_valid = 0;
    repeat (12) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppu_vram_bus_master.md
Name: ppu_vram_bus_master

Overview:
- Bus-master side of the PPU's multiplexed VRAM bus: drives address low byte and data on one shared 8-bit AD bus, pulses ALE, and drives PA[13:8] plus /RD and /WR strobes.
- The external LS373-style address latch demultiplexes AD[7:0] using ALE at the far end.
- Upstream, the PPU fetch logic issues single read/write requests through a valid/ready handshake and receives one response per request.

Parameters:
- ALE_CYCLES, 1, cycles ALE is held high with the address driven (>=1).
- ACC_CYCLES, 2, cycles /RD or /WR is held low (>=1).

Ports:
- clk  in  1  system clock
- n_reset  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept (high only in IDLE)
- req_we  in  1  1 = write, 0 = read
- req_addr  in  14  VRAM address
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle completion pulse (reads and writes)
- rsp_rdata  out  8  read data, valid with rsp_valid on reads
- ale  out  1  address latch enable
- ad_out  out  8  AD bus drive value
- ad_oe  out  1  AD bus output enable (top level builds the tristate)
- ad_in  in  8  AD bus sampled value
- pa_hi  out  6  PA[13:8]
- n_rd  out  1  read strobe, active low
- n_wr  out  1  write strobe, active low

Behaviour:
- One clock, clk. Reset n_reset is asynchronous and active-low.
- All bus outputs are registered; req_ready is decoded from state.
- Reset values:
  - ale=0, ad_oe=0, ad_out=0x00, pa_hi=0, n_rd=1, n_wr=1
  - rsp_valid=0, rsp_rdata=0x00
  - state=IDLE, so req_ready=1 once reset is released.
- Acceptance:
  - A request is accepted on the rising edge where req_valid & req_ready.
  - req_we, req_addr and req_wdata are captured at that edge; later changes are ignored.
- States:
  - IDLE: ale=0, ad_oe=0, strobes high. On accept, go to ADDR.
  - ADDR, ALE_CYCLES cycles: ale=1, ad_oe=1, ad_out=addr[7:0], pa_hi=addr[13:8].
  - HOLD, 1 cycle: ale=0; address remains driven so the latch captures on the ALE falling edge.
  - ACCESS, ACC_CYCLES cycles:
    - Read: n_rd=0, ad_oe=0.
    - Write: n_wr=0, ad_oe=1, ad_out=wdata.
    - Read data: ad_in is sampled into rsp_rdata on the edge that ends the last ACCESS cycle.
  - END, 1 cycle: n_rd=n_wr=1, ad_oe=0 (turnaround), rsp_valid=1. Then go to IDLE.
- Timing with defaults:
  - Accept at edge E0.
  - ADDR is cycle 1, HOLD cycle 2, ACCESS cycles 3–4, END cycle 5 (rsp_valid), IDLE cycle 6 (req_ready=1).
  - Transaction period is ALE_CYCLES+ACC_CYCLES+3 cycles, so back-to-back requests are spaced 6 cycles apart.
- pa_hi holds the last transaction's value until the next ADDR.
- On writes, rsp_rdata keeps its previous read value.
- Invariants:
  - n_rd and n_wr are never both low.
  - ad_oe=0 whenever n_rd=0.
  - ale=0 whenever either strobe is low.
  - Strobes are glitch-free (directly from flops).
- Reset mid-operation: asserting n_reset forces all reset values immediately (asynchronous). The transaction is aborted and no rsp_valid is produced for it.
- Counters are sized clog2(max(ALE_CYCLES,ACC_CYCLES))+1 and reload on every state entry.

Test Plan:
- Reset: hold n_reset=0 -> ale=0, ad_oe=0, n_rd=n_wr=1, rsp_valid=0, req_ready=1 after release.
- Read 0x2ABC with ad_in=0x5A during ACCESS:
  - cycle 1: ale=1, ad_out=0xBC, pa_hi=0x2A
  - cycle 2: ale=0, ad_out=0xBC
  - cycles 3–4: n_rd=0, ad_oe=0
  - cycle 5: rsp_valid=1, rsp_rdata=0x5A
- Write 0x3F00 data 0x0F:
  - cycle 1: ad_out=0x00, pa_hi=0x3F
  - cycles 3–4: n_wr=0, ad_oe=1, ad_out=0x0F
  - cycle 5: rsp_valid=1, rsp_rdata unchanged
- Back-to-back: req_valid held high with two reads -> second accept exactly 6 cycles after the first; two rsp_valid pulses; the first request's inputs are unchanged after changing them mid-transaction.
- Reset asserted during ACCESS of a write -> n_wr=1 and ad_oe=0 in the same cycle, no rsp_valid; a following read completes normally.
- ALE_CYCLES=2, ACC_CYCLES=3 -> ale high 2 cycles, n_rd low 3 cycles, rsp_valid in cycle 7, req_ready in cycle 8.
